midi_note_decoder: RTL and testbench

Converts the raw MIDI byte stream from the UART receiver into single-cycle note events for the synthesis pipeline. Its outputs drive the pipeline's note and note_ready inputs directly.
- Full MIDI message framing: running status, interleaved real-time bytes, SysEx skipping.
- Monophonic gating: a note-off reaches the pipeline only if it releases the currently sounding note.

---
 rtl/midi_note_decoder.sv | 161 ++++++++++++++++
 tb/tb_midi_note_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_decoder.sv
// Purpose : frames the raw MIDI byte stream into single-cycle note events for a monophonic synth voice.
// Latency : note_ready pulses one cycle after the cycle carrying the final data byte of a note message.
// Backpress: none; every rx_valid byte is consumed in its cycle, and back-to-back bytes are handled.
//
// Ports:
//   clock_50_000_000 - system clock
//   reset            - synchronous active-high reset; drops any partial message and the held note
//   rx_byte/rx_valid - byte stream from the UART receiver, one byte per valid cycle
//   note_status      - 1 = ON, 0 = OFF for the last emitted event
//   note_number      - note number of the last emitted event
//   note_velocity    - velocity of the last emitted event (0 for OFF)
//   note_ready       - one-cycle strobe, note_* valid this cycle
//   active           - a note is currently held
//
// Build option: define MIDI_CHANNEL_FILTER_EN to accept only channel CHANNEL; messages on other
// channels are still framed (so their data bytes are not misread) but never produce events.
module midi_note_decoder #(
  parameter int DATA_WIDTH = 7,
  parameter int CHANNEL    = 0
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  note_status,
  output logic [DATA_WIDTH-1:0] note_number,
  output logic [DATA_WIDTH-1:0] note_velocity,
  output logic                  note_ready,
  output logic                  active
);

  localparam logic NOTE_ON  = 1'b1;
  localparam logic NOTE_OFF = 1'b0;

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2,
    SYSEX = 2'd3
  } state_t;

  state_t                state_q, state_d;
  // Only the upper nibble of running status matters for framing and decoding.
  // Zero means "no running status" since every channel status has bit 7 set.
  logic [3:0]            rs_hi_q, rs_hi_d;
  logic                  foreign_q, foreign_d;
  logic [DATA_WIDTH-1:0] d1_q;
  logic [DATA_WIDTH-1:0] held_q;

  logic                  d1_load;
  logic                  ev_on;
  logic                  ev_off;

  logic                  is_realtime;
  logic                  is_status;
  logic                  foreign_status;
  logic                  one_byte_msg;
  logic                  note_msg;
  logic [DATA_WIDTH-1:0] data_byte;

  assign is_realtime    = (rx_byte[7:3] == 5'b11111);
  assign is_status      = rx_byte[7];
  assign foreign_status = FILTER_EN && (rx_byte[3:0] != CHANNEL[3:0]);
  assign one_byte_msg   = (rs_hi_q == 4'hC) || (rs_hi_q == 4'hD);
  assign note_msg       = (rs_hi_q == 4'h8) || (rs_hi_q == 4'h9);
  assign data_byte      = rx_byte[DATA_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    rs_hi_d   = rs_hi_q;
    foreign_d = foreign_q;
    d1_load   = 1'b0;
    ev_on     = 1'b0;
    ev_off    = 1'b0;

    // Real-time bytes may land anywhere, even inside a message, and must leave no trace.
    if (rx_valid && !is_realtime) begin
      if (is_status) begin
        if (rx_byte[7:4] != 4'hF) begin
          rs_hi_d   = rx_byte[7:4];
          foreign_d = foreign_status;
          state_d   = DATA1;
        end else if (rx_byte == 8'hF0) begin
          rs_hi_d   = 4'h0;
          foreign_d = 1'b0;
          state_d   = SYSEX;
        end else begin
          // F1-F7: system common (or SysEx end) cancels running status.
          rs_hi_d   = 4'h0;
          foreign_d = 1'b0;
          state_d   = IDLE;
        end
      end else begin
        unique case (state_q)
          DATA1: begin
            // One-byte messages (program change, channel pressure) complete here and never
            // carry note events, so nothing is latched.
            if (!one_byte_msg) begin
              d1_load = 1'b1;
              state_d = DATA2;
            end
          end
          DATA2: begin
            state_d = DATA1;
            if (note_msg && !foreign_q) begin
              if ((rs_hi_q == 4'h9) && (data_byte != '0)) begin
                ev_on = 1'b1;
              end else if (active && (d1_q == held_q)) begin
                // Mono gating: only releasing the sounding note reaches the pipeline.
                ev_off = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_q       <= IDLE;
      rs_hi_q       <= 4'h0;
      foreign_q     <= 1'b0;
      d1_q          <= '0;
      held_q        <= '0;
      note_status   <= NOTE_OFF;
      note_number   <= '0;
      note_velocity <= '0;
      note_ready    <= 1'b0;
      active        <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_hi_q    <= rs_hi_d;
      foreign_q  <= foreign_d;
      note_ready <= ev_on || ev_off;
      if (d1_load) begin
        d1_q <= data_byte;
      end
      if (ev_on) begin
        note_status   <= NOTE_ON;
        note_number   <= d1_q;
        note_velocity <= data_byte;
        held_q        <= d1_q;
        active        <= 1'b1;
      end else if (ev_off) begin
        note_status   <= NOTE_OFF;
        note_number   <= d1_q;
        note_velocity <= '0;
        active        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: directed message sequences followed by a random byte stream.
// A reference interpreter predicts note events into a queue; a monitor pops and compares
// every note_ready pulse, including the exact cycle it appears.
module tb_midi_note_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       note_status;
  logic [6:0] note_number;
  logic [6:0] note_velocity;
  logic       note_ready;
  logic       active;

  midi_note_decoder #(.DATA_WIDTH(7), .CHANNEL(0)) dut (
    .clock_50_000_000 (clk),
    .reset            (reset),
    .rx_byte          (rx_byte),
    .rx_valid         (rx_valid),
    .note_status      (note_status),
    .note_number      (note_number),
    .note_velocity    (note_velocity),
    .note_ready       (note_ready),
    .active           (active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic       st;
    logic [6:0] num;
    logic [6:0] vel;
    logic       act;
    longint     at;
  } ev_t;

  ev_t        expq[$];
  int         m_rs;       // running status byte, -1 when none (idle or inside SysEx)
  bit         m_foreign;
  logic [6:0] m_data[$];  // data bytes collected for the current message
  bit         m_act;
  logic [6:0] m_held;
  localparam int CH = 0;

  task automatic model_clear();
    m_rs = -1;
    m_foreign = 1'b0;
    m_data.delete();
    m_act = 1'b0;
    m_held = '0;
    expq.delete();
  endtask

  task automatic model_complete(input int kind, input logic [6:0] n, input logic [6:0] v, input longint at);
    ev_t e;
    if (kind == 9 && v != 0) begin
      m_held = n;
      m_act  = 1'b1;
      e.st = 1'b1; e.num = n; e.vel = v; e.act = 1'b1; e.at = at;
      expq.push_back(e);
    end else if ((kind == 8 || kind == 9) && m_act && n == m_held) begin
      m_act = 1'b0;
      e.st = 1'b0; e.num = n; e.vel = 7'd0; e.act = 1'b0; e.at = at;
      expq.push_back(e);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input longint at);
    int need;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_data.delete();
      if (b < 8'hF0) begin
        m_rs = int'(b);
`ifdef MIDI_CHANNEL_FILTER_EN
        m_foreign = (b[3:0] != CH[3:0]);
`else
        m_foreign = 1'b0;
`endif
      end else begin
        m_rs = -1;
        m_foreign = 1'b0;
      end
      return;
    end
    if (m_rs < 0) return;
    m_data.push_back(b[6:0]);
    need = ((m_rs >> 4) == 12 || (m_rs >> 4) == 13) ? 1 : 2;
    if (m_data.size() == need) begin
      if (need == 2 && !m_foreign) model_complete(m_rs >> 4, m_data[0], m_data[1], at);
      m_data.delete();
    end
  endtask

  // ---------------- monitor ----------------
  ev_t mon_e;
  always @(negedge clk) begin
    if (note_ready === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got pulse st=%0b num=%0d vel=%0d, required no pulse (cycle %0d)",
                 note_status, note_number, note_velocity, cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("event_fields", {16'd0, note_status, note_number, note_velocity, active},
            {16'd0, mon_e.st, mon_e.num, mon_e.vel, mon_e.act});
        chk("event_cycle", cyc[31:0], mon_e.at[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    model_byte(b, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_status"}, 32'(note_status), 32'd0);
    chk({tag, "_number"}, 32'(note_number), 32'd0);
    chk({tag, "_velocity"}, 32'(note_velocity), 32'd0);
    chk({tag, "_ready"}, 32'(note_ready), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
  endtask

  task automatic drain(input string tag);
    idle(3);
    chk({tag, "_pending"}, 32'(expq.size()), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'(m_act));
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [6:0] pool [3];
    pool[0] = 7'h3C; pool[1] = 7'h3E; pool[2] = 7'h40;
    r = $urandom_range(0, 99);
    if (r < 55) begin
      r = $urandom_range(0, 9);
      if (r < 4) return {1'b0, pool[$urandom_range(0, 2)]};
      if (r < 6) return 8'h00;
      return {1'b0, 7'($urandom)};
    end
    if (r < 75) return {($urandom_range(0, 1) == 0) ? 4'h8 : 4'h9, 4'($urandom)};
    if (r < 83) return {4'($urandom_range(10, 14)), 4'($urandom)};
    if (r < 89) return 8'($urandom_range(8'hF8, 8'hFF));
    if (r < 93) return 8'hF0;
    if (r < 96) return 8'hF7;
    return 8'($urandom_range(8'hF1, 8'hF6));
  endfunction

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("reset");

    // Basic note-on, with explicit values as well as the scoreboard.
    send(8'h90); send(8'h3C); send(8'h64);
    idle(2);
    chk("basic_status", 32'(note_status), 32'd1);
    chk("basic_number", 32'(note_number), 32'd60);
    chk("basic_velocity", 32'(note_velocity), 32'd100);
    chk("basic_active", 32'(active), 32'd1);
    drain("basic");

    // Running status and velocity-0 release.
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50); send(8'h3E); send(8'h00);
    drain("running");
    chk("running_released", 32'(active), 32'd0);

    // Mono gating: release of a different note is dropped.
    send(8'h90); send(8'h3C); send(8'h64); send(8'h80); send(8'h40); send(8'h00);
    drain("gate_drop");
    chk("gate_still_active", 32'(active), 32'd1);
    send(8'h80); send(8'h3C); send(8'h40);
    drain("gate_release");

    // Real-time bytes interleaved, consecutive cycles.
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
    drain("realtime");

    // SysEx and framing.
    send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7); send(8'h3C); send(8'h64);
    drain("sysex");
    send(8'hC0); send(8'h05); send(8'h90); send(8'h3C); send(8'h64);
    drain("prog_change");
    send(8'hB0); send(8'h07); send(8'h7F); send(8'h3C); send(8'h64);
    drain("control_change");

    // Reset in the middle of a message.
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    idle(3);
    check_zero("mid_reset");
    chk("mid_reset_pending", 32'(expq.size()), 32'd0);

`ifdef MIDI_CHANNEL_FILTER_EN
    send(8'h91); send(8'h3C); send(8'h64);
    drain("foreign_channel");
    chk("foreign_no_event", 32'(note_ready), 32'd0);
`endif

    // Random stream.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle(1);
        do_reset();
      end
      send(rand_byte());
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
